// File: rtl/alu_seq_unit.sv
// alu_seq_unit: registered ALU with built-in ALUOp/function decode and an
// iterative shift-add multiplier behind a start/done handshake.
// Single-cycle operations complete one clock after start. A multiply takes
// WIDTH iterations after the start cycle.
// Build option: define ALU_MULT_EN to compile in the multiplier datapath and
// the MUL state. Without it, the MULT code decodes as illegal, busy is tied
// low, and the unit never leaves IDLE.

module alu_seq_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       alu_op,
   input  logic [5:0]       alu_function,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             illegal
);

   // Internal operation selector produced by the decoder.
   typedef enum logic [2:0] {
      OP_AND,
      OP_OR,
      OP_NOR,
      OP_ADD,
      OP_SUB,
      OP_INC,
      OP_MULT,
      OP_ILLEGAL
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] alu_value;

   // Output registers shared by both build variants.
   logic             done_d,    done_q;
   logic [WIDTH-1:0] result_d,  result_q;
   logic             zero_d,    zero_q;
   logic             illegal_d, illegal_q;

   // Decode {alu_op, alu_function}. The function field only matters for
   // R-type (alu_op = 111); every other ALUOp selects an operation directly.
   always_comb begin
      op = OP_ILLEGAL;
      case (alu_op)
         3'b111: begin
            case (alu_function)
               6'b100100: op = OP_AND;
               6'b100101: op = OP_OR;
               6'b100111: op = OP_NOR;
               6'b100000: op = OP_ADD;
               6'b100010: op = OP_SUB;
               default:   op = OP_ILLEGAL;
            endcase
         end
         3'b100:  op = OP_ADD;
         3'b101:  op = OP_OR;
         3'b001:  op = OP_SUB;
         3'b011:  op = OP_INC;
`ifdef ALU_MULT_EN
         3'b010:  op = OP_MULT;
`else
         3'b010:  op = OP_ILLEGAL;
`endif
         default: op = OP_ILLEGAL;
      endcase
   end

   // Single-cycle datapath. Illegal and MULT codes yield zero here; MULT
   // takes its result from the iterative accumulator instead.
   always_comb begin
      alu_value = '0;
      case (op)
         OP_AND:  alu_value = a & b;
         OP_OR:   alu_value = a | b;
         OP_NOR:  alu_value = ~(a | b);
         OP_ADD:  alu_value = a + b;
         OP_SUB:  alu_value = a - b;
         OP_INC:  alu_value = a + WIDTH'(1);
         default: alu_value = '0;
      endcase
   end

`ifdef ALU_MULT_EN

   // The counter is one bit wider than needed to index WIDTH iterations so
   // that the terminal count can never be reached by wrapping.
   localparam int CNT_W = $clog2(WIDTH) + 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic {
      S_IDLE,
      S_MUL
   } state_e;

   state_e           state_d,  state_q;
   logic [WIDTH-1:0] acc_d,    acc_q;
   logic [WIDTH-1:0] mcand_d,  mcand_q;
   logic [WIDTH-1:0] mplier_d, mplier_q;
   logic [CNT_W-1:0] cnt_d,    cnt_q;
   logic [WIDTH-1:0] acc_sum;

   // One shift-add step: add the shifted multiplicand when the current
   // multiplier LSB is set. Bits shifted past WIDTH are dropped, which gives
   // the low half of the product directly.
   always_comb begin
      acc_sum = acc_q + (mplier_q[0] ? mcand_q : '0);
   end

   // Next-state and datapath control. Requests are only sampled in IDLE, so
   // a start during MUL is simply dropped, and the latched operand copies
   // make the multiply immune to input changes while it runs.
   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      cnt_d     = cnt_q;
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (op == OP_MULT) begin
                  mcand_d  = a;
                  mplier_d = b;
                  acc_d    = '0;
                  cnt_d    = '0;
                  state_d  = S_MUL;
               end else begin
                  result_d  = alu_value;
                  zero_d    = (alu_value == '0);
                  illegal_d = (op == OP_ILLEGAL);
                  done_d    = 1'b1;
               end
            end
         end
         S_MUL: begin
            acc_d    = acc_sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_LAST) begin
               state_d   = S_IDLE;
               result_d  = acc_sum;
               zero_d    = (acc_sum == '0);
               illegal_d = 1'b0;
               done_d    = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State, multiplier and output registers; reset aborts any multiply.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         cnt_q     <= '0;
         done_q    <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   // busy covers exactly the iteration cycles; done is raised on the way
   // back to IDLE, so the two never overlap.
   always_comb begin
      busy = (state_q == S_MUL);
   end

`else

   // Without the multiplier every accepted request finishes in one cycle.
   always_comb begin
      result_d  = result_q;
      zero_d    = zero_q;
      illegal_d = illegal_q;
      done_d    = 1'b0;
      if (start) begin
         result_d  = alu_value;
         zero_d    = (alu_value == '0);
         illegal_d = (op == OP_ILLEGAL);
         done_d    = 1'b1;
      end
   end

   // Output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         done_q    <= 1'b0;
         result_q  <= '0;
         zero_q    <= 1'b1;
         illegal_q <= 1'b0;
      end else begin
         done_q    <= done_d;
         result_q  <= result_d;
         zero_q    <= zero_d;
         illegal_q <= illegal_d;
      end
   end

   // No multi-cycle work exists in this build.
   always_comb begin
      busy = 1'b0;
   end

`endif

   // Drive the registered outputs.
   always_comb begin
      done    = done_q;
      result  = result_q;
      zero    = zero_q;
      illegal = illegal_q;
   end

endmodule

// File: tb/tb_alu_seq_unit.sv
// tb_alu_seq_unit: scoreboard bench for alu_seq_unit (WIDTH = 32).
// Expected results are queued when a request is driven and popped when done
// is observed. Multiplier scenarios are compiled only with ALU_MULT_EN.

module tb_alu_seq_unit;

   localparam int W = 32;

   typedef struct packed {
      logic [W-1:0] res;
      logic         ill;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         start = 1'b0;
   logic [2:0]   alu_op = '0;
   logic [5:0]   alu_function = '0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         busy;
   logic         done;
   logic [W-1:0] result;
   logic         zero;
   logic         illegal;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   alu_seq_unit #(.WIDTH(W)) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .alu_op       (alu_op),
      .alu_function (alu_function),
      .a            (a),
      .b            (b),
      .busy         (busy),
      .done         (done),
      .result       (result),
      .zero         (zero),
      .illegal      (illegal)
   );

   always #5 clk = ~clk;

   // Safety net in case something stalls outside the bounded waits.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one start cycle and queue its expected outcome. Returns at the
   // falling edge right after the sampling edge.
   task automatic send(input logic [2:0] op, input logic [5:0] fn,
                       input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] expv, input logic expill);
      exp_t e;
      @(negedge clk);
      alu_op       = op;
      alu_function = fn;
      a            = av;
      b            = bv;
      start        = 1'b1;
      e.res        = expv;
      e.ill        = expill;
      exp_q.push_back(e);
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count falling edges until done; lat = 1 means done right after start.
   task automatic wait_done(input int budget, output int lat);
      lat = 1;
      while (done !== 1'b1 && lat < budget) begin
         @(negedge clk);
         lat++;
      end
      if (done !== 1'b1) lat = -1;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b want 0", done); end
      checks++; if (result !== '0) begin errors++; $display("[TB] FAIL reset_result: got %h want 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL reset_zero: got %b want 1", zero); end
      checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL reset_illegal: got %b want 0", illegal); end
      reset = 1'b0;
   endtask

   task automatic test_alu_ops();
      logic [2:0]   op;
      logic [5:0]   fn;
      logic [W-1:0] av, bv, expv;
      string        name;
      exp_t         e;
      int           lat;
      av = 32'hF0F0_00FF;
      bv = 32'h0FF0_0F01;
      for (int i = 0; i < 7; i++) begin
         case (i)
            0: begin op = 3'b111; fn = 6'b100100; expv = 32'h00F0_0001; name = "and"; end
            1: begin op = 3'b111; fn = 6'b100101; expv = 32'hFFF0_0FFF; name = "or"; end
            2: begin op = 3'b111; fn = 6'b100111; expv = 32'h000F_F000; name = "nor"; end
            3: begin op = 3'b111; fn = 6'b100000; expv = av + bv; name = "add"; end
            4: begin op = 3'b111; fn = 6'b100010; expv = av - bv; name = "sub"; end
            5: begin op = 3'b100; fn = 6'b011011; expv = av + bv; name = "addi"; end
            default: begin op = 3'b101; fn = 6'b110001; expv = av | bv; name = "ori"; end
         endcase
         send(op, fn, av, bv, expv, 1'b0);
         wait_done(4, lat);
         e = exp_q.pop_front();
         checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 1", name, lat); end
         checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL %s_result: got %h want %h", name, result, e.res); end
         checks++; if (zero !== (e.res == '0)) begin errors++; $display("[TB] FAIL %s_zero: got %b want %b", name, zero, (e.res == '0)); end
         checks++; if (illegal !== e.ill) begin errors++; $display("[TB] FAIL %s_illegal: got %b want %b", name, illegal, e.ill); end
         @(negedge clk);
         checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL %s_done_pulse: got %b want 0", name, done); end
      end
   endtask

   task automatic test_branch_inc();
      logic [2:0]   op;
      logic [W-1:0] av, bv, expv;
      string        name;
      exp_t         e;
      int           lat;
      for (int i = 0; i < 4; i++) begin
         case (i)
            0: begin op = 3'b001; av = 32'h1234; bv = 32'h1234; expv = 32'h0; name = "beq_equal"; end
            1: begin op = 3'b001; av = 32'h1234; bv = 32'h1233; expv = 32'h1; name = "beq_differ"; end
            2: begin op = 3'b011; av = 32'hFFFF_FFFF; bv = 32'h5; expv = 32'h0; name = "inc_wrap"; end
            default: begin op = 3'b011; av = 32'h7; bv = 32'h9; expv = 32'h8; name = "inc"; end
         endcase
         send(op, 6'b000000, av, bv, expv, 1'b0);
         wait_done(4, lat);
         e = exp_q.pop_front();
         checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 1", name, lat); end
         checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL %s_result: got %h want %h", name, result, e.res); end
         checks++; if (zero !== (e.res == '0)) begin errors++; $display("[TB] FAIL %s_zero: got %b want %b", name, zero, (e.res == '0)); end
         checks++; if (illegal !== e.ill) begin errors++; $display("[TB] FAIL %s_illegal: got %b want %b", name, illegal, e.ill); end
      end
   endtask

   task automatic test_illegal();
      logic [2:0] op;
      logic [5:0] fn;
      string      name;
      exp_t       e;
      int         lat;
      int         n;
`ifdef ALU_MULT_EN
      n = 3;
`else
      n = 4;
`endif
      for (int i = 0; i < n; i++) begin
         case (i)
            0: begin op = 3'b111; fn = 6'b101010; name = "ill_rtype"; end
            1: begin op = 3'b000; fn = 6'b100000; name = "ill_op000"; end
            2: begin op = 3'b110; fn = 6'b100100; name = "ill_op110"; end
            default: begin op = 3'b010; fn = 6'b000000; name = "ill_mult"; end
         endcase
         send(op, fn, 32'hDEAD_BEEF, 32'h0000_0003, 32'h0, 1'b1);
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL %s_busy: got %b want 0", name, busy); end
         wait_done(4, lat);
         e = exp_q.pop_front();
         checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL %s_latency: got %0d want 1", name, lat); end
         checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL %s_result: got %h want %h", name, result, e.res); end
         checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL %s_zero: got %b want 1", name, zero); end
         checks++; if (illegal !== e.ill) begin errors++; $display("[TB] FAIL %s_illegal: got %b want %b", name, illegal, e.ill); end
      end
   endtask

   task automatic test_back_to_back();
      exp_t e;
      exp_t e2;
      @(negedge clk);
      alu_op = 3'b111; alu_function = 6'b100000; a = 32'd1; b = 32'd2; start = 1'b1;
      e.res = 32'd3; e.ill = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      alu_op = 3'b111; alu_function = 6'b100010; a = 32'd10; b = 32'd4;
      e2.res = 32'd6; e2.ill = 1'b0;
      exp_q.push_back(e2);
      e = exp_q.pop_front();
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done1: got %b want 1", done); end
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL b2b_result1: got %h want %h", result, e.res); end
      @(negedge clk);
      start = 1'b0;
      e = exp_q.pop_front();
      checks++; if (done !== 1'b1) begin errors++; $display("[TB] FAIL b2b_done2: got %b want 1", done); end
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL b2b_result2: got %h want %h", result, e.res); end
      @(negedge clk);
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL b2b_done_end: got %b want 0", done); end
      checks++; if (result !== 32'd6) begin errors++; $display("[TB] FAIL b2b_hold: got %h want 00000006", result); end
   endtask

`ifdef ALU_MULT_EN
   task automatic test_mult();
      logic [W-1:0] av, bv, expv;
      exp_t         e;
      int           lat;
      int           busy_cycles;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin av = 32'h0001_0003; bv = 32'h0001_0005; expv = 32'h0008_000F; end
         else begin av = 32'hFFFF_FFFF; bv = 32'h2; expv = 32'hFFFF_FFFE; end
         send(3'b010, 6'b000000, av, bv, expv, 1'b0);
         lat = 1;
         busy_cycles = 0;
         while (done !== 1'b1 && lat < W + 8) begin
            if (busy === 1'b1) busy_cycles++;
            if (lat == 4) begin
               start = 1'b1; alu_op = 3'b111; alu_function = 6'b100000;
               a = 32'h1111; b = 32'h2222;
            end else begin
               start = 1'b0;
            end
            @(negedge clk);
            lat++;
         end
         start = 1'b0;
         if (done !== 1'b1) lat = -1;
         e = exp_q.pop_front();
         checks++; if (lat !== W + 1) begin errors++; $display("[TB] FAIL mult%0d_latency: got %0d want %0d", i, lat, W + 1); end
         checks++; if (busy_cycles !== W) begin errors++; $display("[TB] FAIL mult%0d_busy_cycles: got %0d want %0d", i, busy_cycles, W); end
         checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL mult%0d_busy_with_done: got %b want 0", i, busy); end
         checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL mult%0d_result: got %h want %h", i, result, e.res); end
         checks++; if (zero !== (e.res == '0)) begin errors++; $display("[TB] FAIL mult%0d_zero: got %b want %b", i, zero, (e.res == '0)); end
         checks++; if (illegal !== 1'b0) begin errors++; $display("[TB] FAIL mult%0d_illegal: got %b want 0", i, illegal); end
         @(negedge clk);
         checks++; if (done !== 1'b0 || busy !== 1'b0) begin errors++; $display("[TB] FAIL mult%0d_after: got done %b busy %b want 0 0", i, done, busy); end
      end
   endtask

   task automatic test_reset_mid_mult();
      exp_t e;
      int   lat;
      int   done_seen;
      send(3'b010, 6'b000000, 32'd3, 32'd5, 32'd15, 1'b0);
      for (int i = 0; i < 5; i++) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      exp_q.delete();
      checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL rstmul_busy: got %b want 0", busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstmul_done: got %b want 0", done); end
      checks++; if (result !== '0) begin errors++; $display("[TB] FAIL rstmul_result: got %h want 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL rstmul_zero: got %b want 1", zero); end
      @(negedge clk);
      reset = 1'b0;
      done_seen = 0;
      for (int i = 0; i < W + 4; i++) begin
         @(negedge clk);
         if (done === 1'b1 || busy === 1'b1) done_seen++;
      end
      checks++; if (done_seen !== 0) begin errors++; $display("[TB] FAIL rstmul_no_done: got %0d active cycles want 0", done_seen); end
      send(3'b111, 6'b100000, 32'd40, 32'd2, 32'd42, 1'b0);
      wait_done(4, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== 1) begin errors++; $display("[TB] FAIL rstmul_add_latency: got %0d want 1", lat); end
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL rstmul_add_result: got %h want %h", result, e.res); end
   endtask
`else
   task automatic test_reset_idle();
      exp_t e;
      int   lat;
      send(3'b111, 6'b100000, 32'd5, 32'd6, 32'd11, 1'b0);
      wait_done(4, lat);
      e = exp_q.pop_front();
      checks++; if (result !== e.res) begin errors++; $display("[TB] FAIL rstidle_pre: got %h want %h", result, e.res); end
      #1 reset = 1'b1;
      #1;
      checks++; if (result !== '0) begin errors++; $display("[TB] FAIL rstidle_result: got %h want 0", result); end
      checks++; if (zero !== 1'b1) begin errors++; $display("[TB] FAIL rstidle_zero: got %b want 1", zero); end
      checks++; if (done !== 1'b0) begin errors++; $display("[TB] FAIL rstidle_done: got %b want 0", done); end
      @(negedge clk);
      reset = 1'b0;
   endtask
`endif

   initial begin
      $display("[TB] alu_seq_unit bench start");
      test_reset();
      test_alu_ops();
      test_branch_inc();
      test_illegal();
      test_back_to_back();
`ifdef ALU_MULT_EN
      test_mult();
      test_reset_mid_mult();
`else
      test_reset_idle();
`endif
      checks++; if (exp_q.size() !== 0) begin errors++; $display("[TB] FAIL scoreboard_empty: got %0d entries want 0", exp_q.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
